// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the cache subsystem (L1, victim cache and
// the main-memory port arbiter).
//   ADDR_WIDTH   byte address width
//   LINE_BYTES   cache line size in bytes
//   OFFSET_BITS  number of byte-offset bits inside a line
//   line_t       one full cache line
//   arb_state_t  memory-port arbiter FSM states
//   port_id_t    which requester owns the outstanding memory transaction
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_BYTES  = 16;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    typedef logic [LINE_BYTES*8-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_L1 = 1'b0,
        PORT_VC = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single line-wide main-memory port between the L1 cache (refills
// and dirty writebacks) and the victim cache (evicted-line writebacks). Only
// one memory transaction is outstanding at a time.
//
// Handshake: a requester raises *_req_valid and holds it, with its rw/addr/
// wdata stable, until the cycle *_req_ready is high; that cycle is the accept.
// *_req_ready is only ever high in IDLE and only for the picked requester.
// Completion is a one-cycle *_resp_valid pulse; *_resp_rdata holds its value
// until the next completion for that port. Towards memory, mem_req_valid is a
// one-cycle pulse and mem_resp_valid is accepted only while waiting for it.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   l1_req_* / l1_resp_*        L1 cache request and completion
//   vc_req_* / vc_resp_*        victim cache request and completion
//   mem_req_* / mem_resp_*      main-memory port
//   l1_grant_cnt, vc_grant_cnt  saturating grant counters
//   dbg_state_o                 current FSM state, for observation only
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = cache_pkg::ADDR_WIDTH,
    parameter int LINE_BYTES   = cache_pkg::LINE_BYTES,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    l1_req_valid,
    output logic                    l1_req_ready,
    input  logic                    l1_req_rw,
    input  logic [ADDR_WIDTH-1:0]   l1_req_addr,
    input  logic [LINE_BYTES*8-1:0] l1_req_wdata,
    output logic                    l1_resp_valid,
    output logic [LINE_BYTES*8-1:0] l1_resp_rdata,

    input  logic                    vc_req_valid,
    output logic                    vc_req_ready,
    input  logic                    vc_req_rw,
    input  logic [ADDR_WIDTH-1:0]   vc_req_addr,
    input  logic [LINE_BYTES*8-1:0] vc_req_wdata,
    output logic                    vc_resp_valid,
    output logic [LINE_BYTES*8-1:0] vc_resp_rdata,

    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [LINE_BYTES*8-1:0] mem_req_wdata,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_rdata,

    output logic [CNT_WIDTH-1:0]    l1_grant_cnt,
    output logic [CNT_WIDTH-1:0]    vc_grant_cnt,

    output arb_state_t              dbg_state_o
);

    localparam int LW  = LINE_BYTES * 8;
    localparam int OFF = $clog2(LINE_BYTES);
    localparam int SW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [SW-1:0]         STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    arb_state_t             state_q,         state_d;
    port_id_t               owner_q,         owner_d;
    logic                   rw_q,            rw_d;
    logic [ADDR_WIDTH-1:0]  addr_q,          addr_d;
    logic [LW-1:0]          wdata_q,         wdata_d;
    logic                   l1_resp_valid_q, l1_resp_valid_d;
    logic                   vc_resp_valid_q, vc_resp_valid_d;
    logic [LW-1:0]          l1_rdata_q,      l1_rdata_d;
    logic [LW-1:0]          vc_rdata_q,      vc_rdata_d;
    logic [SW-1:0]          starve_q,        starve_d;
    logic [CNT_WIDTH-1:0]   l1_cnt_q,        l1_cnt_d;
    logic [CNT_WIDTH-1:0]   vc_cnt_q,        vc_cnt_d;

    // -----------------------------------------------------------------------
    // Picker
    // -----------------------------------------------------------------------
    logic pick_l1;
    logic pick_vc;
    logic both_valid;
    logic same_line;

    always_comb begin
        pick_l1    = 1'b0;
        pick_vc    = 1'b0;
        both_valid = l1_req_valid && vc_req_valid;
        same_line  = (l1_req_addr[ADDR_WIDTH-1:OFF] == vc_req_addr[ADDR_WIDTH-1:OFF]);
        if (state_q == IDLE) begin
            // A pending victim writeback of the line L1 wants to refill must
            // reach memory first, otherwise the refill would read stale data.
            if (both_valid && (same_line || starve_q == STARVE_MAX)) begin
                pick_vc = 1'b1;
            end else if (l1_req_valid) begin
                pick_l1 = 1'b1;
            end else if (vc_req_valid) begin
                pick_vc = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        l1_resp_valid_d = 1'b0;
        vc_resp_valid_d = 1'b0;
        l1_rdata_d      = l1_rdata_q;
        vc_rdata_d      = vc_rdata_q;
        starve_d        = starve_q;
        l1_cnt_d        = l1_cnt_q;
        vc_cnt_d        = vc_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vc) begin
                    owner_d = PORT_VC;
                    rw_d    = vc_req_rw;
                    addr_d  = vc_req_addr & ~OFF_MASK;
                    wdata_d = vc_req_wdata;
                    state_d = ISSUE;
                end else if (pick_l1) begin
                    owner_d = PORT_L1;
                    rw_d    = l1_req_rw;
                    addr_d  = l1_req_addr & ~OFF_MASK;
                    wdata_d = l1_req_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Write acks are returned the same way as read data; the
                // requester simply ignores rdata on a write completion.
                if (mem_resp_valid) begin
                    state_d = IDLE;
                    if (owner_q == PORT_L1) begin
                        l1_resp_valid_d = 1'b1;
                        l1_rdata_d      = mem_resp_rdata;
                    end else begin
                        vc_resp_valid_d = 1'b1;
                        vc_rdata_d      = mem_resp_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Starvation guard: counts L1 grants that overtook a waiting VC.
        if (!vc_req_valid || pick_vc) begin
            starve_d = '0;
        end else if (pick_l1 && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        if (pick_l1 && l1_cnt_q != CNT_MAX) begin
            l1_cnt_d = l1_cnt_q + 1'b1;
        end
        if (pick_vc && vc_cnt_q != CNT_MAX) begin
            vc_cnt_d = vc_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= PORT_L1;
            rw_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            l1_resp_valid_q <= 1'b0;
            vc_resp_valid_q <= 1'b0;
            l1_rdata_q      <= '0;
            vc_rdata_q      <= '0;
            starve_q        <= '0;
            l1_cnt_q        <= '0;
            vc_cnt_q        <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rw_q            <= rw_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            l1_resp_valid_q <= l1_resp_valid_d;
            vc_resp_valid_q <= vc_resp_valid_d;
            l1_rdata_q      <= l1_rdata_d;
            vc_rdata_q      <= vc_rdata_d;
            starve_q        <= starve_d;
            l1_cnt_q        <= l1_cnt_d;
            vc_cnt_q        <= vc_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign l1_req_ready  = pick_l1;
    assign vc_req_ready  = pick_vc;
    assign l1_resp_valid = l1_resp_valid_q;
    assign vc_resp_valid = vc_resp_valid_q;
    assign l1_resp_rdata = l1_rdata_q;
    assign vc_resp_rdata = vc_rdata_q;

    // The latched request stays on the bus from ISSUE until the next accept.
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_rw    = rw_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;

    assign l1_grant_cnt  = l1_cnt_q;
    assign vc_grant_cnt  = vc_cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import cache_pkg::*;

  localparam int AW = 32;
  localparam int LW = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          l1_req_valid = 1'b0;
  logic          l1_req_ready;
  logic          l1_req_rw = 1'b0;
  logic [AW-1:0] l1_req_addr = '0;
  logic [LW-1:0] l1_req_wdata = '0;
  logic          l1_resp_valid;
  logic [LW-1:0] l1_resp_rdata;
  logic          vc_req_valid = 1'b0;
  logic          vc_req_ready;
  logic          vc_req_rw = 1'b0;
  logic [AW-1:0] vc_req_addr = '0;
  logic [LW-1:0] vc_req_wdata = '0;
  logic          vc_resp_valid;
  logic [LW-1:0] vc_resp_rdata;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_rdata;
  logic [15:0]   l1_grant_cnt;
  logic [15:0]   vc_grant_cnt;
  arb_state_t    dbg_state;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .l1_req_valid   (l1_req_valid),
    .l1_req_ready   (l1_req_ready),
    .l1_req_rw      (l1_req_rw),
    .l1_req_addr    (l1_req_addr),
    .l1_req_wdata   (l1_req_wdata),
    .l1_resp_valid  (l1_resp_valid),
    .l1_resp_rdata  (l1_resp_rdata),
    .vc_req_valid   (vc_req_valid),
    .vc_req_ready   (vc_req_ready),
    .vc_req_rw      (vc_req_rw),
    .vc_req_addr    (vc_req_addr),
    .vc_req_wdata   (vc_req_wdata),
    .vc_resp_valid  (vc_resp_valid),
    .vc_resp_rdata  (vc_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .l1_grant_cnt   (l1_grant_cnt),
    .vc_grant_cnt   (vc_grant_cnt),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- 1-cycle memory model: byte i holds i[7:0] ----------------
  logic [LW-1:0] mem_a [logic [AW-1:0]];
  logic          model_rv = 1'b0;
  logic [LW-1:0] model_rd = '0;
  logic          stray_rv = 1'b0;

  assign mem_resp_valid = model_rv | stray_rv;
  assign mem_resp_rdata = model_rd;

  function automatic logic [LW-1:0] pattern(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = a[7:0] + 8'(i);
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    model_rv <= 1'b0;
    if (mem_req_valid) begin
      model_rv <= 1'b1;
      if (mem_req_rw) begin
        mem_a[mem_req_addr] = mem_req_wdata;
        model_rd <= mem_req_wdata;
      end else if (mem_a.exists(mem_req_addr)) begin
        model_rd <= mem_a[mem_req_addr];
      end else begin
        model_rd <= pattern(mem_req_addr);
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [LW-1:0] LINE_40 = 128'h4f4e4d4c_4b4a4948_47464544_43424140;
  localparam logic [LW-1:0] LINE_100 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [LW-1:0] LINE_50 = 128'h5f5e5d5c_5b5a5958_57565554_53525150;
  localparam logic [LW-1:0] W2 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [LW-1:0] WAA = {16{8'hAA}};
  localparam logic [LW-1:0] W4 = 128'h11112222_33334444_55556666_77778888;

  initial begin
    int l1_g;
    int vc_g;
    int vc_at;

    // ---------- reset values ----------
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_state", dbg_state, IDLE);
    chk("rst_l1_ready", l1_req_ready, 1'b0);
    chk("rst_vc_ready", vc_req_ready, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_addr", mem_req_addr, 32'h0);
    chk("rst_l1_resp", l1_resp_valid, 1'b0);
    chk("rst_l1_rdata", l1_resp_rdata, '0);
    chk("rst_l1_cnt", l1_grant_cnt, 16'd0);
    chk("rst_vc_cnt", vc_grant_cnt, 16'd0);

    // ---------- 1: lone L1 read of 0x40 ----------
    l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h40;
    #1;
    chk("t1_l1_ready_c0", l1_req_ready, 1'b1);
    chk("t1_vc_ready_c0", vc_req_ready, 1'b0);
    step(); l1_req_valid = 1'b0; #1;
    chk("t1_mem_valid_c1", mem_req_valid, 1'b1);
    chk("t1_mem_addr_c1", mem_req_addr, 32'h40);
    chk("t1_mem_rw_c1", mem_req_rw, 1'b0);
    chk("t1_l1_ready_c1", l1_req_ready, 1'b0);
    step(); #1;
    chk("t1_state_c2", dbg_state, WAIT);
    chk("t1_mem_valid_c2", mem_req_valid, 1'b0);
    chk("t1_resp_c2", l1_resp_valid, 1'b0);
    step(); #1;
    chk("t1_resp_c3", l1_resp_valid, 1'b1);
    chk("t1_rdata_c3", l1_resp_rdata, LINE_40);
    chk("t1_state_c3", dbg_state, IDLE);
    step(); #1;
    chk("t1_resp_c4", l1_resp_valid, 1'b0);

    // ---------- 2: L1 read 0x100 vs VC write 0x200 ----------
    l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h100;
    vc_req_valid = 1'b1; vc_req_rw = 1'b1; vc_req_addr = 32'h200; vc_req_wdata = W2;
    #1;
    chk("t2_l1_ready", l1_req_ready, 1'b1);
    chk("t2_vc_ready", vc_req_ready, 1'b0);
    step(); l1_req_valid = 1'b0; #1;
    chk("t2_mem_addr_l1", mem_req_addr, 32'h100);
    chk("t2_vc_ready_issue", vc_req_ready, 1'b0);
    step(); step(); #1;
    chk("t2_l1_resp", l1_resp_valid, 1'b1);
    chk("t2_l1_rdata", l1_resp_rdata, LINE_100);
    chk("t2_vc_ready_c3", vc_req_ready, 1'b1);
    step(); vc_req_valid = 1'b0; #1;
    chk("t2_mem_valid_vc", mem_req_valid, 1'b1);
    chk("t2_mem_rw_vc", mem_req_rw, 1'b1);
    chk("t2_mem_addr_vc", mem_req_addr, 32'h200);
    chk("t2_mem_wdata_vc", mem_req_wdata, W2);
    step(); step(); #1;
    chk("t2_vc_resp", vc_resp_valid, 1'b1);
    chk("t2_vc_rdata", vc_resp_rdata, W2);
    chk("t2_l1_resp_quiet", l1_resp_valid, 1'b0);

    // ---------- 3: same-line hazard, VC write 0x80 before L1 read 0x84 ----------
    vc_req_valid = 1'b1; vc_req_rw = 1'b1; vc_req_addr = 32'h80; vc_req_wdata = WAA;
    l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h84;
    #1;
    chk("t3_vc_ready", vc_req_ready, 1'b1);
    chk("t3_l1_ready", l1_req_ready, 1'b0);
    step(); vc_req_valid = 1'b0; #1;
    chk("t3_mem_addr_vc", mem_req_addr, 32'h80);
    chk("t3_mem_rw_vc", mem_req_rw, 1'b1);
    step(); step(); #1;
    chk("t3_vc_resp", vc_resp_valid, 1'b1);
    chk("t3_l1_ready_c3", l1_req_ready, 1'b1);
    step(); l1_req_valid = 1'b0; #1;
    chk("t3_mem_addr_aligned", mem_req_addr, 32'h80);
    chk("t3_mem_rw_l1", mem_req_rw, 1'b0);
    step(); step(); #1;
    chk("t3_l1_resp", l1_resp_valid, 1'b1);
    chk("t3_l1_rdata", l1_resp_rdata, WAA);
    chk("t3_l1_cnt", l1_grant_cnt, 16'd3);
    chk("t3_vc_cnt", vc_grant_cnt, 16'd2);

    // ---------- 4: starvation guard ----------
    do_reset();
    l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h300;
    vc_req_valid = 1'b1; vc_req_rw = 1'b1; vc_req_addr = 32'h400; vc_req_wdata = W4;
    l1_g = 0; vc_g = 0; vc_at = -1;
    for (int c = 0; c < 36; c++) begin
      #1;
      if (l1_req_ready) l1_g++;
      if (vc_req_ready) begin
        vc_g++;
        if (vc_at < 0) vc_at = l1_g;
      end
      step();
      if (l1_g >= 6) l1_req_valid = 1'b0;
      if (vc_g >= 1) vc_req_valid = 1'b0;
    end
    #1;
    chk("t4_vc_after_l1", 128'(vc_at), 128'(4));
    chk("t4_l1_grants", 128'(l1_g), 128'(6));
    chk("t4_vc_grants", 128'(vc_g), 128'(1));
    chk("t4_vc_cnt", vc_grant_cnt, 16'd1);
    chk("t4_l1_cnt", l1_grant_cnt, 16'd6);
    chk("t4_state", dbg_state, IDLE);

    // ---------- 5: reset during WAIT, stray response, then normal read ----------
    do_reset();
    l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h40;
    #1;
    step(); l1_req_valid = 1'b0;
    step(); #1;
    chk("t5_state_wait", dbg_state, WAIT);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("t5_resp_after_rst", l1_resp_valid, 1'b0);
    chk("t5_state_after_rst", dbg_state, IDLE);
    chk("t5_l1_cnt_after_rst", l1_grant_cnt, 16'd0);
    chk("t5_mem_valid_after_rst", mem_req_valid, 1'b0);
    step(); #1;
    chk("t5_resp_late", l1_resp_valid, 1'b0);
    stray_rv = 1'b1;
    step(); stray_rv = 1'b0; #1;
    chk("t5_stray_state", dbg_state, IDLE);
    chk("t5_stray_l1_resp", l1_resp_valid, 1'b0);
    chk("t5_stray_vc_resp", vc_resp_valid, 1'b0);
    l1_req_valid = 1'b1; l1_req_rw = 1'b0; l1_req_addr = 32'h5c;
    #1;
    chk("t5_ready", l1_req_ready, 1'b1);
    step(); l1_req_valid = 1'b0; #1;
    chk("t5_mem_addr", mem_req_addr, 32'h50);
    step(); step(); #1;
    chk("t5_resp", l1_resp_valid, 1'b1);
    chk("t5_rdata", l1_resp_rdata, LINE_50);
    chk("t5_l1_cnt", l1_grant_cnt, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
